commit_unit: RTL and testbench
==============================

Name: commit_unit

Overview:
- In-order retirement stage directly downstream of the ROB.
- Each cycle it examines the ROB head entry and, when that entry is done, retires it:
  - architectural regfile write,
  - ROB dequeue,
  - retire-order tagging.
- Serializes committed stores to the store path through a req/ack handshake.
- On a branch misprediction, raises the pipeline-wide flush and PC redirect, then holds a drain window before resuming.

Parameters:
- FLUSH_CYCLES, 2, cycles spent in FLUSH after a mispredict before commit resumes (range 1..15)
- ORDER_W, 64, width of the retire-order counter

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- head_entry_i  in  rob_entry_t  ROB entry currently at head
- rob_empty_i  in  1  ROB holds no entries
- dequeue_o  out  1  pop ROB head this cycle
- rf_we_o  out  1  architectural regfile write enable
- rf_rd_addr_o  out  5  destination register
- rf_rd_data_o  out  32  write data
- rf_rob_idx_o  out  5  ROB index of the retiring entry (clears RAT mapping if it still matches)
- st_req_o  out  1  committed-store request to store path
- st_addr_o  out  32  store address
- st_wmask_o  out  4  store byte mask
- st_wdata_o  out  32  store data
- st_ack_i  in  1  store path accepted request
- flush_o  out  1  pipeline flush pulse
- pc_redirect_o  out  32  fetch redirect target, valid with flush_o
- commit_valid_o  out  1  an instruction retired this cycle
- order_o  out  ORDER_W  retire order of the retiring instruction
- mispredict_cnt_o  out  32  saturating count of mispredicts
- busy_o  out  1  state != RUN

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=RUN; drain counter=0; order=0; mispredict_cnt=0.
  - All registered outputs = 0, including st_req_o, flush_o and pc_redirect_o.
- States and transitions:
  - RUN, STORE_WAIT, FLUSH.
- Retire-ready condition:
  - ready = !rob_empty_i && head_entry_i.valid && head_entry_i.status==done.
- RUN, ready, non-store, non-mispredict:
  - Same-cycle combinational retire: dequeue_o=1, commit_valid_o=1, order_o=current order.
  - Order increments at the edge.
  - rf_we_o = regf_we && rd_addr!=0; rf_rd_data_o = rd_data; rf_rob_idx_o = rd_rob_idx.
  - Stay in RUN.
  - Throughput: one retire per cycle.
- RUN, ready, store (mem_wmask!=0):
  - Register st_req_o=1 with mem_addr, mem_wmask and mem_wdata.
  - Go to STORE_WAIT; no dequeue yet.
- STORE_WAIT:
  - st_req_o and its payload are held stable until st_ack_i=1.
  - Cycle st_ack_i=1: retire the store (dequeue_o=1, commit_valid_o=1, rf_we_o=0); st_req_o drops next cycle; return to RUN.
  - st_ack_i may arrive in the same cycle req first appears → retire at that ack, single-cycle STORE_WAIT.
- RUN, ready, branch (op_type==op_br) with br_en != prediction:
  - Retire the branch (including rf write for JAL/JALR link) and dequeue in the same cycle.
  - Next cycle: flush_o=1 for exactly one cycle; pc_redirect_o = pc_new registered from the entry.
  - mispredict_cnt increments, saturating at 32'hFFFF_FFFF.
  - Enter FLUSH with drain counter = FLUSH_CYCLES.
- FLUSH:
  - No dequeue, rf_we_o or st_req_o regardless of head contents.
  - Counter decrements each cycle; exits to RUN when it reaches 0.
  - Total FLUSH_CYCLES cycles in FLUSH, the first of which carries flush_o.
- Correct-predicted branch: treated as a normal retire.
- Priority: reset > FLUSH hold > STORE_WAIT > RUN retire.
- Head not ready or ROB empty: all strobes 0, state held.
- Wrap-around:
  - order wraps modulo 2^ORDER_W.
  - ROB index wrap is the ROB's concern; this block passes rd_rob_idx through.
- Reset mid-STORE_WAIT: request dropped immediately next cycle; no retire.
- Reset mid-FLUSH: counter cleared, RUN.

Decomposition:
- Shared package additions (rv32i_types):
  - commit_state_t enum {RUN, STORE_WAIT, FLUSH}
  - constant FLUSH_CYCLES_DEFAULT
- Reused from the package: rob_entry_t, status encoding (done), op_br.
- Sub-module: commit_mispredict_ctr, a saturating 32-bit counter with inc/clear.
- The rest stays flat: one always_ff for state/registers, one always_comb for retire decode.

Test Plan:
- ALU retire:
  - Stimulus: head {valid, done, regf_we=1, rd=5, rd_data=32'h1234, rd_rob_idx=7}, order=0.
  - Response: same cycle dequeue_o=1, rf_we_o=1, rf_rd_addr_o=5, rf_rd_data_o=32'h1234, order_o=0; next retire shows order_o=1.
- x0 destination:
  - Stimulus: rd=0, regf_we=1.
  - Response: rf_we_o=0, dequeue_o=1, commit_valid_o=1.
- Store handshake:
  - Stimulus: head store mem_addr=32'h1000, wmask=4'hF, wdata=32'hDEADBEEF; st_ack_i held 0 for 3 cycles then 1.
  - Response: st_req_o stable with that payload for 4 cycles; dequeue_o=1 only on the ack cycle; st_req_o=0 the cycle after.
- Mispredict:
  - Stimulus: head branch br_en=1, prediction=0, pc_new=32'h60000040, FLUSH_CYCLES=2.
  - Response:
    - cycle0: dequeue_o=1.
    - cycle1: flush_o=1, pc_redirect_o=32'h60000040, busy_o=1.
    - cycles 1–2: no dequeue despite a done head.
    - cycle3: retire resumes.
    - mispredict_cnt_o=1.
- Correct prediction:
  - Stimulus: br_en=1, prediction=1.
  - Response: normal retire, flush_o never asserted, mispredict_cnt_o=0.
- Reset mid-STORE_WAIT:
  - Stimulus: rst_n=0 for one cycle while st_req_o=1.
  - Response: st_req_o=0, busy_o=0, order_o=0 next cycle; no dequeue.

Source files
------------

// File: rtl/commit_unit_pkg.sv
// Shared types for the commit stage: ROB entry layout, status/op encodings and commit FSM states.
package commit_unit_pkg;

    localparam int FLUSH_CYCLES_DEFAULT = 2;

    typedef enum logic [1:0] {
        waiting = 2'd0,
        issued  = 2'd1,
        done    = 2'd2
    } rob_status_t;

    typedef enum logic [1:0] {
        op_alu = 2'd0,
        op_br  = 2'd1,
        op_ld  = 2'd2,
        op_st  = 2'd3
    } op_type_t;

    typedef struct packed {
        logic        valid;
        rob_status_t status;
        op_type_t    op_type;
        logic        regf_we;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic [4:0]  rd_rob_idx;
        logic [31:0] mem_addr;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
        logic        br_en;
        logic        prediction;
        logic [31:0] pc_new;
    } rob_entry_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } commit_state_t;

    // Jumps are tagged op_br with br_en=1, so a mispredicted jump also flushes.
    function automatic logic is_mispredict(input rob_entry_t e);
        return (e.op_type == op_br) && (e.br_en != e.prediction);
    endfunction

endpackage

// File: rtl/commit_unit_if.sv
// Bundles the ROB-head, regfile, store-path and redirect signals of the commit stage.
interface commit_unit_if #(
    parameter int ORDER_W = 64
);
    import commit_unit_pkg::*;

    rob_entry_t           head_entry_i;
    logic                 rob_empty_i;
    logic                 dequeue_o;
    logic                 rf_we_o;
    logic [4:0]           rf_rd_addr_o;
    logic [31:0]          rf_rd_data_o;
    logic [4:0]           rf_rob_idx_o;
    logic                 st_req_o;
    logic [31:0]          st_addr_o;
    logic [3:0]           st_wmask_o;
    logic [31:0]          st_wdata_o;
    logic                 st_ack_i;
    logic                 flush_o;
    logic [31:0]          pc_redirect_o;
    logic                 commit_valid_o;
    logic [ORDER_W-1:0]   order_o;
    logic [31:0]          mispredict_cnt_o;
    logic                 busy_o;

    modport master (
        input  head_entry_i, rob_empty_i, st_ack_i,
        output dequeue_o, rf_we_o, rf_rd_addr_o, rf_rd_data_o, rf_rob_idx_o,
               st_req_o, st_addr_o, st_wmask_o, st_wdata_o,
               flush_o, pc_redirect_o, commit_valid_o, order_o,
               mispredict_cnt_o, busy_o
    );

    modport slave (
        output head_entry_i, rob_empty_i, st_ack_i,
        input  dequeue_o, rf_we_o, rf_rd_addr_o, rf_rd_data_o, rf_rob_idx_o,
               st_req_o, st_addr_o, st_wmask_o, st_wdata_o,
               flush_o, pc_redirect_o, commit_valid_o, order_o,
               mispredict_cnt_o, busy_o
    );

endinterface

// File: rtl/commit_unit_mispredict_ctr.sv
// Saturating 32-bit event counter used to track branch mispredicts.
module commit_mispredict_ctr (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    input  logic        i_clear,
    output logic [31:0] o_count
);

    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != 32'hFFFF_FFFF)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/commit_unit.sv
// In-order retirement stage: retires the ROB head, serialises stores and flushes on mispredicts.
module commit_unit
    import commit_unit_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
    parameter int ORDER_W      = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    commit_unit_if.master bus
);

    commit_state_t      r_state;
    logic [3:0]         r_drain;
    logic [ORDER_W-1:0] r_order;
    logic               r_st_req;
    logic [31:0]        r_st_addr;
    logic [3:0]         r_st_wmask;
    logic [31:0]        r_st_wdata;
    logic               r_flush;
    logic [31:0]        r_pc_redirect;

    commit_state_t      w_next_state;
    logic               w_ready;
    logic               w_retire;
    logic               w_rf_we;
    logic               w_start_store;
    logic               w_start_flush;
    logic [31:0]        w_misp_cnt;

    // Retire decode; reset suppresses every strobe so a late ack cannot retire.
    always_comb begin
        w_next_state  = r_state;
        w_retire      = 1'b0;
        w_rf_we       = 1'b0;
        w_start_store = 1'b0;
        w_start_flush = 1'b0;
        w_ready       = !bus.rob_empty_i && bus.head_entry_i.valid
                        && (bus.head_entry_i.status == done);
        if (!rst_n) begin
            w_next_state = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_ready) begin
                        if (bus.head_entry_i.mem_wmask != 4'd0) begin
                            w_start_store = 1'b1;
                            w_next_state  = STORE_WAIT;
                        end else begin
                            w_retire = 1'b1;
                            w_rf_we  = bus.head_entry_i.regf_we
                                       && (bus.head_entry_i.rd_addr != 5'd0);
                            if (is_mispredict(bus.head_entry_i)) begin
                                w_start_flush = 1'b1;
                                w_next_state  = FLUSH;
                            end
                        end
                    end
                end
                STORE_WAIT: begin
                    if (bus.st_ack_i) begin
                        w_retire     = 1'b1;
                        w_next_state = RUN;
                    end
                end
                FLUSH: begin
                    if (r_drain <= 4'd1) begin
                        w_next_state = RUN;
                    end
                end
                default: w_next_state = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_drain       <= '0;
            r_order       <= '0;
            r_st_req      <= 1'b0;
            r_st_addr     <= '0;
            r_st_wmask    <= '0;
            r_st_wdata    <= '0;
            r_flush       <= 1'b0;
            r_pc_redirect <= '0;
        end else begin
            r_state <= w_next_state;
            r_flush <= w_start_flush;
            if (w_retire) begin
                r_order <= r_order + 1'b1;
            end
            if (w_start_store) begin
                r_st_req   <= 1'b1;
                r_st_addr  <= bus.head_entry_i.mem_addr;
                r_st_wmask <= bus.head_entry_i.mem_wmask;
                r_st_wdata <= bus.head_entry_i.mem_wdata;
            end else if ((r_state == STORE_WAIT) && bus.st_ack_i) begin
                r_st_req <= 1'b0;
            end
            if (w_start_flush) begin
                r_pc_redirect <= bus.head_entry_i.pc_new;
                r_drain       <= 4'(FLUSH_CYCLES);
            end else if (r_state == FLUSH) begin
                r_drain <= r_drain - 1'b1;
            end
        end
    end

    commit_mispredict_ctr u_misp_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_start_flush),
        .i_clear (1'b0),
        .o_count (w_misp_cnt)
    );

    assign bus.dequeue_o        = w_retire;
    assign bus.commit_valid_o   = w_retire;
    assign bus.rf_we_o          = w_rf_we;
    assign bus.rf_rd_addr_o     = w_retire ? bus.head_entry_i.rd_addr    : 5'd0;
    assign bus.rf_rd_data_o     = w_retire ? bus.head_entry_i.rd_data    : 32'd0;
    assign bus.rf_rob_idx_o     = w_retire ? bus.head_entry_i.rd_rob_idx : 5'd0;
    assign bus.st_req_o         = r_st_req;
    assign bus.st_addr_o        = r_st_addr;
    assign bus.st_wmask_o       = r_st_wmask;
    assign bus.st_wdata_o       = r_st_wdata;
    assign bus.flush_o          = r_flush;
    assign bus.pc_redirect_o    = r_pc_redirect;
    assign bus.order_o          = r_order;
    assign bus.mispredict_cnt_o = w_misp_cnt;
    assign bus.busy_o           = (r_state != RUN);

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: directed scenarios then random traffic against a behavioural model.
module tb_commit_unit;
    import commit_unit_pkg::*;

    localparam int FLUSH_CYCLES = 2;
    localparam int ORDER_W      = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    commit_unit_if #(.ORDER_W(ORDER_W)) bus ();

    commit_unit #(.FLUSH_CYCLES(FLUSH_CYCLES), .ORDER_W(ORDER_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checkCount = 0;
    int failCount  = 0;

    // Reference model: what is owed to the outside world, not how the DUT stores it.
    bit          mStorePending = 0;
    rob_entry_t  mStoreEntry   = '0;
    int          mFlushLeft    = 0;
    bit          mFlushPulse   = 0;
    logic [31:0] mRedirect     = '0;
    int unsigned mOrder        = 0;
    longint      mMisp         = 0;
    bit          mJustReset    = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic rob_entry_t mkEntry(input op_type_t op, input bit regfWe, input logic [4:0] rd,
                                           input logic [31:0] data, input logic [4:0] idx);
        rob_entry_t e;
        e = '0;
        e.valid      = 1'b1;
        e.status     = done;
        e.op_type    = op;
        e.regf_we    = regfWe;
        e.rd_addr    = rd;
        e.rd_data    = data;
        e.rd_rob_idx = idx;
        return e;
    endfunction

    function automatic rob_entry_t randEntry();
        rob_entry_t e;
        e.valid      = ($urandom_range(0, 9) != 0);
        e.status     = ($urandom_range(0, 3) != 0) ? done : rob_status_t'($urandom_range(0, 1));
        e.op_type    = op_type_t'($urandom_range(0, 3));
        e.regf_we    = 1'($urandom_range(0, 1));
        e.rd_addr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        e.rd_data    = $urandom;
        e.rd_rob_idx = 5'($urandom);
        e.mem_addr   = $urandom;
        e.mem_wmask  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        e.mem_wdata  = $urandom;
        e.br_en      = 1'($urandom_range(0, 1));
        e.prediction = 1'($urandom_range(0, 1));
        e.pc_new     = $urandom;
        return e;
    endfunction

    // Drive one cycle of inputs, compare against the model, then advance the model across the edge.
    task automatic applyStimulus(input rob_entry_t e, input bit empty, input bit ack, input bit rstn);
        bit ready;
        bit expRetire;
        bit expRfWe;
        bit newPulse;
        @(negedge clk);
        bus.head_entry_i = e;
        bus.rob_empty_i  = empty;
        bus.st_ack_i     = ack;
        rst_n            = rstn;
        #1;
        if (!rstn) begin
            checkOutput("dequeue_in_reset", 64'(bus.dequeue_o), 64'd0);
            checkOutput("commit_in_reset", 64'(bus.commit_valid_o), 64'd0);
            checkOutput("rf_we_in_reset", 64'(bus.rf_we_o), 64'd0);
            mStorePending = 0;
            mFlushLeft    = 0;
            mFlushPulse   = 0;
            mRedirect     = '0;
            mOrder        = 0;
            mMisp         = 0;
            mJustReset    = 1;
            return;
        end
        checkOutput("busy", 64'(bus.busy_o), 64'(mStorePending || (mFlushLeft > 0)));
        checkOutput("st_req", 64'(bus.st_req_o), 64'(mStorePending));
        if (mStorePending) begin
            checkOutput("st_addr", 64'(bus.st_addr_o), 64'(mStoreEntry.mem_addr));
            checkOutput("st_wmask", 64'(bus.st_wmask_o), 64'(mStoreEntry.mem_wmask));
            checkOutput("st_wdata", 64'(bus.st_wdata_o), 64'(mStoreEntry.mem_wdata));
        end
        checkOutput("flush", 64'(bus.flush_o), 64'(mFlushPulse));
        if (mFlushPulse || mJustReset) begin
            checkOutput("pc_redirect", 64'(bus.pc_redirect_o), 64'(mRedirect));
        end
        checkOutput("misp_cnt", 64'(bus.mispredict_cnt_o), 64'(mMisp));
        if (mJustReset) begin
            checkOutput("order_after_reset", 64'(bus.order_o), 64'd0);
        end
        mJustReset = 0;

        ready     = !empty && e.valid && (e.status == done);
        expRetire = 0;
        expRfWe   = 0;
        newPulse  = 0;
        if (mFlushLeft > 0) begin
            mFlushLeft--;
        end else if (mStorePending) begin
            if (ack) begin
                expRetire     = 1;
                mStorePending = 0;
            end
        end else if (ready) begin
            if (e.mem_wmask != 4'd0) begin
                mStorePending = 1;
                mStoreEntry   = e;
            end else begin
                expRetire = 1;
                expRfWe   = e.regf_we && (e.rd_addr != 5'd0);
                if ((e.op_type == op_br) && (e.br_en != e.prediction)) begin
                    mFlushLeft = FLUSH_CYCLES;
                    newPulse   = 1;
                    mRedirect  = e.pc_new;
                    if (mMisp < 64'hFFFF_FFFF) mMisp++;
                end
            end
        end
        checkOutput("dequeue", 64'(bus.dequeue_o), 64'(expRetire));
        checkOutput("commit_valid", 64'(bus.commit_valid_o), 64'(expRetire));
        checkOutput("rf_we", 64'(bus.rf_we_o), 64'(expRfWe));
        if (expRetire) begin
            checkOutput("order", 64'(bus.order_o), 64'(mOrder));
            checkOutput("rf_rob_idx", 64'(bus.rf_rob_idx_o), 64'(e.rd_rob_idx));
            mOrder = (mOrder + 1) % (1 << ORDER_W);
        end
        if (expRfWe) begin
            checkOutput("rf_rd_addr", 64'(bus.rf_rd_addr_o), 64'(e.rd_addr));
            checkOutput("rf_rd_data", 64'(bus.rf_rd_data_o), 64'(e.rd_data));
        end
        mFlushPulse = newPulse;
    endtask

    initial begin
        rob_entry_t idle;
        rob_entry_t e;
        rob_entry_t st;
        bit empty;
        bit ack;
        bit rstn;

        idle = '0;
        bus.head_entry_i = '0;
        bus.rob_empty_i  = 1'b1;
        bus.st_ack_i     = 1'b0;

        applyStimulus(idle, 1, 0, 0);
        applyStimulus(idle, 1, 0, 0);
        applyStimulus(idle, 1, 0, 1);

        $display("[TB] ALU retire and x0 destination");
        applyStimulus(mkEntry(op_alu, 1, 5'd5, 32'h1234, 5'd7), 0, 0, 1);
        applyStimulus(mkEntry(op_alu, 1, 5'd9, 32'h55AA, 5'd8), 0, 0, 1);
        applyStimulus(mkEntry(op_alu, 1, 5'd0, 32'hFFFF, 5'd9), 0, 0, 1);

        $display("[TB] store handshake");
        st = mkEntry(op_st, 0, 5'd0, 32'd0, 5'd10);
        st.mem_addr  = 32'h1000;
        st.mem_wmask = 4'hF;
        st.mem_wdata = 32'hDEADBEEF;
        applyStimulus(st, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(st, 0, 0, 1);
        applyStimulus(st, 0, 1, 1);
        applyStimulus(idle, 1, 0, 1);

        $display("[TB] mispredict and drain");
        e = mkEntry(op_br, 1, 5'd1, 32'h44, 5'd11);
        e.br_en = 1'b1; e.prediction = 1'b0; e.pc_new = 32'h60000040;
        applyStimulus(e, 0, 0, 1);
        applyStimulus(mkEntry(op_alu, 1, 5'd3, 32'h1, 5'd12), 0, 0, 1);
        applyStimulus(mkEntry(op_alu, 1, 5'd3, 32'h1, 5'd12), 0, 0, 1);
        applyStimulus(mkEntry(op_alu, 1, 5'd3, 32'h1, 5'd12), 0, 0, 1);

        $display("[TB] correct prediction");
        e = mkEntry(op_br, 0, 5'd0, 32'h0, 5'd13);
        e.br_en = 1'b1; e.prediction = 1'b1; e.pc_new = 32'h7000_0000;
        applyStimulus(e, 0, 0, 1);
        applyStimulus(idle, 1, 0, 1);

        $display("[TB] reset during store wait");
        applyStimulus(st, 0, 0, 1);
        applyStimulus(st, 0, 0, 1);
        applyStimulus(st, 0, 1, 0);
        applyStimulus(idle, 1, 0, 1);

        $display("[TB] random traffic");
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rstn  = ($urandom_range(0, 199) != 0);
            ack   = ($urandom_range(0, 2) == 0);
            empty = ($urandom_range(0, 7) == 0);
            e     = randEntry();
            if (mStorePending) begin
                e     = mStoreEntry;
                empty = 0;
            end
            applyStimulus(e, empty, ack, rstn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
